comb_selftest: RTL
==================

Name: comb_selftest

Overview:
- Sequential built-in self-test engine for the S/P/V→LED combinational block (`comb`).
- Acts as the opposite end of that interface. It drives S, P, V through all 8 input combinations, samples the returned LED and compares each sample against an expected truth table.
- Reports per-vector failures, a failure count and an overall pass/done status.
- Sits beside `comb` in hardware, replacing the stimulus-only testbench with an on-chip checker.

Parameters:
- DWELL_CYCLES, 4, clocks each vector is held before LED is sampled (>=1; >=3 when SELFTEST_SYNC_EN is defined)
- EXPECTED, 8'hE8, expected LED per vector; bit i = expected LED when {S,P,V} == i (default = 2-of-3 majority)

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a test run
- S  out  1  stimulus to comb, = idx[2]
- P  out  1  stimulus to comb, = idx[1]
- V  out  1  stimulus to comb, = idx[0]
- LED  in  1  response from comb
- busy  out  1  high while a run is in progress
- done  out  1  high once a run completes; sticky until the next accepted start
- pass  out  1  high when done==1 and fail_mask==0
- fail_mask  out  8  bit i set when vector i mismatched
- fail_count  out  4  number of mismatching vectors, 0..8

Behaviour:
- Interface fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (any time, including mid-run):
  - state=IDLE, idx=0, timer=0;
  - S=P=V=0, busy=0, done=0, pass=0, fail_mask=0, fail_count=0;
  - takes effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start==1 at edge t0:
  - state←RUN, idx←0, timer←0;
  - fail_mask←0, fail_count←0, done←0, busy←1.
- RUN, each edge:
  - if timer != DWELL_CYCLES-1: timer←timer+1;
  - else compare the sampled LED with EXPECTED[idx];
  - on mismatch set fail_mask[idx] and increment fail_count (same edge);
  - then timer←0; if idx==7: state←DONE, else idx←idx+1.
- Timing: vector i is driven from edge t0+i*DWELL_CYCLES; its sample is taken at edge t0+(i+1)*DWELL_CYCLES.
- Completion: done=1 and busy=0 from edge t0+8*DWELL_CYCLES. The final compare is included in fail_mask/fail_count/pass on that same edge.
- S/P/V: registered, equal to idx while in RUN; 0 in IDLE and DONE (the DONE transition also drives 000).
- start while in RUN: ignored, with no effect on idx, timer or results.
- start in DONE: restarts, clearing all results on the accepting edge.
- pass: combinational, done & (fail_mask==0); 0 whenever done==0.
- Widths:
  - timer is $clog2(DWELL_CYCLES) bits, minimum 1;
  - fail_count saturates at 8 by construction;
  - no wrap of idx beyond 7.

Optional Feature:
- Macro: SELFTEST_SYNC_EN.
- Defined:
  - LED passes through a 2-flop synchroniser (reset to 0) before the compare.
  - The value compared at the sample edge is LED as of two clocks earlier.
  - DWELL_CYCLES must be >=3; an elaboration-time check errors otherwise.
- Undefined:
  - LED is compared directly at the sample edge.
  - Any DWELL_CYCLES >= 1 is allowed.

Decomposition:
- Package comb_selftest_pkg:
  - state enum {IDLE, RUN, DONE};
  - NUM_VECTORS=8, IDX_W=3, CNT_W=4.
- One sub-module is natural: dwell_timer.
  - Parameter: DWELL_CYCLES.
  - Inputs: clk, rst_n, clear, enable.
  - Output: expire, high in the cycle timer==DWELL_CYCLES-1.
- Top level holds the FSM, the idx register, result registers and the optional synchroniser.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → S,P,V,busy,done,pass,fail_mask,fail_count all 0; assert at the rst_n fall with no clock edge.
- Nominal, DWELL_CYCLES=4, LED=majority(S,P,V):
  - pulse start → {S,P,V} steps 000..111, 4 clocks each;
  - done=1 exactly 32 clocks after the start edge, busy drops on the same edge;
  - pass=1, fail_mask=8'h00, fail_count=0.
- LED stuck at 0 → fail_mask=8'hE8, fail_count=4, pass=0; done still at 32 clocks.
- LED=S&P (faulty model) → fail_mask=8'h28 (idx 3,5), fail_count=2, pass=0.
- Start interference and mid-run reset:
  - start re-pulsed at clock 10 of a run → ignored, done still at clock 32;
  - rst_n low at clock 12 → all outputs 0 asynchronously, state IDLE;
  - new start → full 32-clock run, pass=1.
- SELFTEST_SYNC_EN defined, DWELL_CYCLES=4, LED=majority → pass=1, fail_mask=0.
- SELFTEST_SYNC_EN defined, DWELL_CYCLES=2 → elaboration error.

Source files
------------

// File: rtl/comb_selftest_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comb_selftest_pkg
// Brief    : Shared types and sizes for the comb_selftest BIST engine.
// Revision : 1.0 - initial release
// ============================================================================
package comb_selftest_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : comb_selftest_pkg
`default_nettype wire

// File: rtl/comb_selftest_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dwell_timer
// Brief    : Wrapping dwell counter; expire flags the last cycle of a vector.
// Revision : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TMR_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [TMR_W-1:0] c_LAST = TMR_W'(DWELL_CYCLES - 1);

    generate
        if (DWELL_CYCLES < 1) begin : g_dwell_check
            $error("dwell_timer: DWELL_CYCLES must be >= 1");
        end
    endgenerate

    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (clear) begin
            r_timer <= '0;
        end else if (enable) begin
            r_timer <= expire ? '0 : r_timer + TMR_W'(1);
        end
    end

    assign expire = (r_timer == c_LAST);

endmodule : dwell_timer
`default_nettype wire

// File: rtl/comb_selftest.sv
`default_nettype none
// ============================================================================
// Module   : comb_selftest
// Brief    : Built-in self-test for the S/P/V->LED block: sweeps all 8 inputs,
//            checks LED against EXPECTED. Macro SELFTEST_SYNC_EN adds a 2-flop
//            LED synchroniser ahead of the compare.
// Revision : 1.0 - initial release
// ============================================================================
module comb_selftest
    import comb_selftest_pkg::*;
#(
    parameter int         DWELL_CYCLES = 4,
    parameter logic [7:0] EXPECTED     = 8'hE8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             S,
    output logic             P,
    output logic             V,
    input  logic             LED,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_mask,
    output logic [CNT_W-1:0] fail_count
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_stim;
    logic [7:0]       r_fail_mask;
    logic [CNT_W-1:0] r_fail_count;
    logic             w_led_cmp;
    logic             w_accept;
    logic             w_expire;
    logic             w_sample;
    logic             w_last;

`ifdef SELFTEST_SYNC_EN
    logic [1:0] r_sync;

    generate
        if (DWELL_CYCLES < 3) begin : g_sync_dwell_check
            $error("comb_selftest: DWELL_CYCLES must be >= 3 with the LED synchroniser");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], LED};
        end
    end

    assign w_led_cmp = r_sync[1];
`else
    assign w_led_cmp = LED;
`endif

    // start is only honoured outside RUN; a re-pulse mid-run is dropped here.
    assign w_accept = (r_state != RUN) && start;
    assign w_sample = (r_state == RUN) && w_expire;
    assign w_last   = (r_idx == c_LAST_IDX);

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_accept),
        .enable (r_state == RUN),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next_state = RUN;
            RUN:        if (w_sample && w_last) w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_stim       <= '0;
            r_fail_mask  <= '0;
            r_fail_count <= '0;
        end else if (w_accept) begin
            r_idx        <= '0;
            r_stim       <= '0;
            r_fail_mask  <= '0;
            r_fail_count <= '0;
        end else if (w_sample) begin
            if (w_led_cmp != EXPECTED[r_idx]) begin
                r_fail_mask[r_idx] <= 1'b1;
                r_fail_count       <= r_fail_count + CNT_W'(1);
            end
            // Stimulus returns to 000 on the DONE transition; idx parks at 7.
            if (w_last) begin
                r_stim <= '0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_stim <= r_idx + IDX_W'(1);
            end
        end
    end

    assign {S, P, V}  = r_stim;
    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign fail_mask  = r_fail_mask;
    assign fail_count = r_fail_count;
    assign pass       = done && (r_fail_mask == 8'h00);

endmodule : comb_selftest
`default_nettype wire
